// File: rtl/fmap_bank_reader_pkg.sv
// Shared definitions for the feature-map bank read path: map geometry,
// lane-vector type and controller state encoding.
package fmap_bank_reader_pkg;

   localparam int FMAP_W  = 111;
   localparam int FMAP_H  = 111;
   localparam int LANE_W  = 16;
   localparam int N_LANES = 8;
   localparam int BANK_AW = 32;

   // One bank word: lane 0 occupies the low LANE_W bits.
   typedef logic [N_LANES-1:0][LANE_W-1:0] lanevec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fmap_bank_reader_lanevec_fifo2.sv
// Two-entry FIFO holding {lane vector, eol, last}. The head entry is
// presented combinationally and only changes when it is popped.
module lanevec_fifo2
   import fmap_bank_reader_pkg::*;
#(
   parameter int W = $bits(lanevec_t) + 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy; push+pop together keeps the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fmap_bank_reader.sv
// Raster-scan read controller for the 8-lane feature-map bank. Issues one
// read per free buffer slot, captures the returned lane vector with its
// row/map position tags, and streams it to the expand stage.
//
// Stream handshake: a beat moves on every rising edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready low, m_data,
// m_eol and m_last hold their value. m_valid never waits on m_ready.
module fmap_bank_reader
   import fmap_bank_reader_pkg::*;
#(
   parameter int WIDTH  = FMAP_W,
   parameter int HEIGHT = FMAP_H,
   parameter int DW     = LANE_W,
   parameter int LANES  = N_LANES,
   parameter int AW     = BANK_AW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                rden,
   output logic [AW-1:0]       rdaddr,
   input  logic [DW*LANES-1:0] rddata,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DW*LANES-1:0] m_data,
   output logic                m_eol,
   output logic                m_last,
   output logic [1:0]          dbg_state
);

   localparam int XW = cnt_w(WIDTH);
   localparam int YW = cnt_w(HEIGHT);

   state_t          state;
   state_t          state_nx;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            x_end;
   logic            y_end;
   logic            start_acc;
   logic [1:0]      fifo_cnt;
   logic            fifo_pop;

   assign x_end     = (x == XW'(WIDTH - 1));
   assign y_end     = (y == YW'(HEIGHT - 1));
   assign m_valid   = (fifo_cnt != 2'd0);
   assign fifo_pop  = m_valid && m_ready;
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: leave RUN on the final address, leave DRAIN once the
   // buffer is empty (straight back into RUN if a start arrives then).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (rden && x_end && y_end) state_nx = DRAIN;
         DRAIN:   if (fifo_cnt == 2'd0) state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs. The bank answers at the edge that closes the rden cycle, so
   // the credit check is simply the registered buffer occupancy: a read is
   // only issued when a slot is guaranteed free for its data.
   always_comb begin
      rden      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         RUN: begin
            busy = 1'b1;
            rden = (fifo_cnt != 2'd2);
         end
         DRAIN: begin
            busy = (fifo_cnt != 2'd0);
            done = (fifo_cnt == 2'd0);
         end
         default: ;
      endcase
      start_acc = start && ((state == IDLE) || done);
   end

   // Scan position and address; the address stops on the last location.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x      <= '0;
         y      <= '0;
         rdaddr <= '0;
      end else if (start_acc) begin
         x      <= '0;
         y      <= '0;
         rdaddr <= '0;
      end else if (rden) begin
         if (x_end) begin
            x <= '0;
            if (!y_end) y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
         if (!(x_end && y_end)) rdaddr <= rdaddr + AW'(1);
      end
   end

   lanevec_fifo2 #(
      .W(DW*LANES + 2)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rden),
      .pop   (fifo_pop),
      .wdata ({rddata, x_end, x_end && y_end}),
      .rdata ({m_data, m_eol, m_last}),
      .count (fifo_cnt)
   );

endmodule

// File: tb/tb_fmap_bank_reader.sv
// Directed bench: a 4x3 instance for stream/backpressure/reset behaviour
// and a default-size instance for the full 111x111 scan.
module tb_fmap_bank_reader;
   import fmap_bank_reader_pkg::*;

   localparam int SW  = 4;
   localparam int SH  = 3;
   localparam int NB  = SW * SH;
   localparam int LW  = FMAP_W;
   localparam int LNB = FMAP_W * FMAP_H;
   localparam int DWL = LANE_W * N_LANES;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic           s_start = 1'b0, s_m_ready = 1'b0;
   logic           s_busy, s_done, s_rden, s_m_valid, s_m_eol, s_m_last;
   logic [31:0]    s_rdaddr;
   logic [DWL-1:0] s_rddata, s_m_data;
   logic [1:0]     s_dbg;

   logic           l_start = 1'b0, l_m_ready = 1'b0;
   logic           l_busy, l_done, l_rden, l_m_valid, l_m_eol, l_m_last;
   logic [31:0]    l_rdaddr;
   logic [DWL-1:0] l_rddata, l_m_data;
   logic [1:0]     l_dbg;

   // Bank contents: lane k at address a holds a*8+k.
   function automatic logic [DWL-1:0] bank_word(input int a);
      logic [DWL-1:0] w;
      w = '0;
      for (int k = 0; k < N_LANES; k++) w[k*LANE_W +: LANE_W] = LANE_W'(a*8 + k);
      return w;
   endfunction

   always_comb s_rddata = bank_word(int'(s_rdaddr));
   always_comb l_rddata = bank_word(int'(l_rdaddr));

   fmap_bank_reader #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
      .rden(s_rden), .rdaddr(s_rdaddr), .rddata(s_rddata),
      .m_valid(s_m_valid), .m_ready(s_m_ready), .m_data(s_m_data),
      .m_eol(s_m_eol), .m_last(s_m_last), .dbg_state(s_dbg)
   );

   fmap_bank_reader dut_l (
      .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
      .rden(l_rden), .rdaddr(l_rdaddr), .rddata(l_rddata),
      .m_valid(l_m_valid), .m_ready(l_m_ready), .m_data(l_m_data),
      .m_eol(l_m_eol), .m_last(l_m_last), .dbg_state(l_dbg)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [DWL+1:0] exp_q[$];
   int iss_cnt, acc_cnt, done_cnt, rden_cnt, step_no, done_step;
   logic prev_stall;
   logic [DWL+1:0] prev_head;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_reset();
      exp_q.delete();
      iss_cnt = 0; acc_cnt = 0; done_cnt = 0; rden_cnt = 0;
      done_step = -1; prev_stall = 1'b0; prev_head = '0;
      for (int i = 0; i < NB; i++)
         exp_q.push_back({bank_word(i), ((i % SW) == SW-1), (i == NB-1)});
   endtask

   // ---------------- driver / monitor for the 4x3 instance ----------------
   // Inputs change at the falling edge; outputs are sampled 1 time unit later.
   task automatic step_s(input logic st, input logic rdy);
      logic [DWL+1:0] head, e;
      @(negedge clk);
      s_start   = st;
      s_m_ready = rdy;
      #1;
      step_no++;
      head = {s_m_data, s_m_eol, s_m_last};
      if (s_rden) begin
         chk("rd_addr", s_rdaddr, iss_cnt);
         iss_cnt++;
         rden_cnt++;
         chk("outstanding_le2", ((iss_cnt - acc_cnt) > 2), 0);
      end
      if (s_m_valid && prev_stall) chk("stall_hold", head, prev_head);
      if (s_m_valid && s_m_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("beat", head, e);
         end
         acc_cnt++;
      end
      prev_stall = s_m_valid && !s_m_ready;
      prev_head  = head;
      if (s_done) begin
         done_cnt++;
         done_step = step_no;
      end
   endtask

   // mode 0: ready high; 1: ready 1,0,0,1...; 2: ready low 10 cycles; 3: restart at beat 5
   task automatic run_scan(input int mode, input string tag);
      int   n;
      logic rdy, st, kicked;
      sb_reset();
      kicked  = 1'b0;
      step_no = -1;
      step_s(1'b1, (mode == 2) ? 1'b0 : 1'b1);
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         n++;
         case (mode)
            1:       rdy = ((n % 4) == 0) || ((n % 4) == 3);
            2:       rdy = (n > 10);
            default: rdy = 1'b1;
         endcase
         st = (mode == 3) && (acc_cnt == 5) && !kicked;
         if (st) kicked = 1'b1;
         step_s(st, rdy);
         if (mode == 0 && n == 1) chk({tag, "_busy_rden_c1"}, {s_busy, s_rden, s_m_valid}, 3'b110);
         if (mode == 0 && n == 2) chk({tag, "_valid_c2"}, s_m_valid, 1'b1);
         if (mode == 2 && n == 10) chk({tag, "_full_valid"}, {s_m_valid, s_rden}, 2'b10);
         if (mode == 2 && n == 11) chk({tag, "_rden_before_accept"}, rden_cnt, 2);
      end
      if (done_cnt == 0) chk({tag, "_timeout"}, 1, 0);
      if (mode == 0) chk({tag, "_done_cycle"}, done_step, 14);
      for (int i = 0; i < 3; i++) step_s(1'b0, 1'b1);
      chk({tag, "_beats"}, acc_cnt, NB);
      chk({tag, "_left"}, exp_q.size(), 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_rden_cnt"}, rden_cnt, NB);
      chk({tag, "_idle"}, {s_busy, s_m_valid, s_dbg}, 4'b0000);
   endtask

   // ---------------- full-size scan, back-to-back restart ----------------
   task automatic run_big();
      int n, beats, errs, last_at, last_cnt, last_rd, rdens, dstep, rd_at_done;
      @(negedge clk);
      l_start   = 1'b1;
      l_m_ready = 1'b1;
      n = 0; beats = 0; errs = 0; last_at = -1; last_cnt = 0;
      last_rd = -1; rdens = 0; dstep = -1; rd_at_done = -1;
      while (dstep < 0 && n < LNB + 50) begin
         @(negedge clk);
         l_start = 1'b0;
         #1;
         n++;
         if (l_rden) begin
            if (int'(l_rdaddr) != rdens) errs++;
            last_rd = int'(l_rdaddr);
            rdens++;
         end
         if (l_m_valid) begin
            if (l_m_data !== bank_word(beats)) errs++;
            if (l_m_eol !== ((beats % LW) == LW-1)) errs++;
            if (l_m_last) begin
               last_at = beats;
               last_cnt++;
            end
            beats++;
         end
         if (l_done) begin
            dstep      = n;
            rd_at_done = int'(l_rdaddr);
            l_start    = 1'b1;
         end
      end
      if (dstep < 0) chk("l_timeout", 1, 0);
      chk("l_beats", beats, LNB);
      chk("l_errs", errs, 0);
      chk("l_last_at", last_at, LNB-1);
      chk("l_last_cnt", last_cnt, 1);
      chk("l_final_rdaddr", last_rd, LNB-1);
      chk("l_rdaddr_at_done", rd_at_done, LNB-1);
      chk("l_rden_cnt", rdens, LNB);
      chk("l_done_cycle", dstep, LNB+2);
      @(negedge clk);
      l_start = 1'b0;
      #1;
      chk("l_restart_busy_rden", {l_busy, l_rden}, 2'b11);
      chk("l_restart_addr", l_rdaddr, 0);
      @(negedge clk);
      #1;
      chk("l_restart_beat0", {l_m_valid, l_m_data}, {1'b1, bank_word(0)});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      #1;
      chk("reset_ctrl", {s_busy, s_done, s_rden, s_m_valid, s_m_eol, s_m_last}, 6'b0);
      chk("reset_addr_data", {s_rdaddr, s_m_data}, 0);
      chk("reset_state", {s_dbg, l_dbg}, 4'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_scan(0, "basic");
      run_scan(1, "toggle");
      run_scan(2, "hold10");
      run_scan(3, "restart");

      // Reset in the middle of a scan, then a clean rescan.
      sb_reset();
      step_no = -1;
      step_s(1'b1, 1'b1);
      n = 0;
      while (acc_cnt < 6 && n < 50) begin
         n++;
         step_s(1'b0, 1'b1);
      end
      chk("mid_scan_busy", {s_busy, s_m_valid}, 2'b11);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_ctrl", {s_busy, s_done, s_rden, s_m_valid, s_m_eol, s_m_last}, 6'b0);
      chk("arst_addr", s_rdaddr, 0);
      chk("arst_data", s_m_data, 0);
      chk("arst_state", s_dbg, 2'b00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_scan(0, "after_rst");

      run_big();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
